icache_assoc: RTL and testbench

Parametrised set-associative instruction cache. It is the next-generation replacement for the direct-mapped icache instantiated inside caches.
- Datapath side: the icache modport of datapath_cache_if.
- Memory side: the icache channel of cache_control_if, indexed by CPUID.
- New relative to the previous icache: configurable sets, ways and block size, multi-word block fill, a single-cycle invalidate, and saturating hit/miss counters.

---
 rtl/cpu_types_pkg.sv | 8 +
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_tag_array.sv | 81 ++++++++
 rtl/icache_assoc.sv | 204 ++++++++++++++++++++
 tb/tb_icache_assoc.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the cache hierarchy.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/icache_pkg.sv
// Types, constants and address-field helpers for the set-associative icache.
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;

    // Widths of the word-offset, set-index and tag fields of a fetch address.
    typedef struct packed {
        logic [7:0] woff_w;
        logic [7:0] idx_w;
        logic [7:0] tag_w;
    } field_w_t;

    function automatic field_w_t field_widths(input int sets, input int blkwords);
        field_w_t fw;
        fw.woff_w = 8'($clog2(blkwords));
        fw.idx_w  = 8'($clog2(sets));
        fw.tag_w  = 8'(ADDR_W - $clog2(WORD_BYTES) - $clog2(blkwords) - $clog2(sets));
        return fw;
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// SETS x WAYS storage of tags, valid bits and block data, plus one
// round-robin replacement pointer per set. Combinational read port for
// lookup, word-wide write port for fills, global flush of the valid bits.
module icache_tag_array
    import icache_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2,
    localparam field_w_t FW = field_widths(SETS, BLKWORDS),
    localparam int WOFF_W  = int'(FW.woff_w),
    localparam int WOFF_SW = (WOFF_W > 0) ? WOFF_W : 1,
    localparam int IDX_W   = int'(FW.idx_w),
    localparam int TAG_W   = int'(FW.tag_w),
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    flush_i,
    // lookup
    input  logic [IDX_W-1:0]        rd_idx_i,
    input  logic [WOFF_SW-1:0]      rd_woff_i,
    output logic [WAYS-1:0]         rd_valid_o,
    output logic [WAYS*TAG_W-1:0]   rd_tag_o,
    output logic [WAYS*WORD_W-1:0]  rd_data_o,
    output logic [WAY_W-1:0]        rd_ptr_o,
    // fill
    input  logic                    wr_en_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic [WAY_W-1:0]        wr_way_i,
    input  logic [WOFF_SW-1:0]      wr_woff_i,
    input  logic [WORD_W-1:0]       wr_data_i,
    input  logic                    commit_i,
    input  logic [TAG_W-1:0]        wr_tag_i
);

    logic [SETS-1:0][WAYS-1:0]  valid_q;
    logic [SETS-1:0][WAY_W-1:0] ptr_q;
    logic [TAG_W-1:0]           tag_q  [SETS][WAYS];
    word_t                      data_q [SETS][WAYS][BLKWORDS];

    // Round-robin successor; with a single way it stays at zero.
    function automatic logic [WAY_W-1:0] ptr_next(input logic [WAY_W-1:0] p);
        return (p == WAY_W'(WAYS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Valid bits and replacement pointers; flush beats a completing fill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (commit_i) begin
            valid_q[wr_idx_i][wr_way_i] <= 1'b1;
            ptr_q[wr_idx_i]             <= ptr_next(ptr_q[wr_idx_i]);
        end
    end

    // Tag and data storage written during fills.
    // NOTE: tag/data arrays are deliberately not reset; the valid bits alone
    // give them meaning, and leaving them reset-free lets them map onto RAM.
    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_way_i][wr_woff_i] <= wr_data_i;
        end
        if (commit_i) begin
            tag_q[wr_idx_i][wr_way_i] <= wr_tag_i;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_rd
        assign rd_valid_o[w]                  = valid_q[rd_idx_i][w];
        assign rd_tag_o[w*TAG_W +: TAG_W]     = tag_q[rd_idx_i][w];
        assign rd_data_o[w*WORD_W +: WORD_W]  = data_q[rd_idx_i][w][rd_woff_i];
    end

    assign rd_ptr_o = ptr_q[rd_idx_i];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: zero-latency hits in IDLE, multi-word
// block fill from memory in FILL, single-cycle flush, saturating counters.
module icache_assoc
    import icache_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int CPUID    = 0,
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    // datapath side
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    // memory side
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    // statistics
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam field_w_t FW = field_widths(SETS, BLKWORDS);
    localparam int WOFF_W   = int'(FW.woff_w);
    localparam int WOFF_SW  = (WOFF_W > 0) ? WOFF_W : 1;
    localparam int IDX_W    = int'(FW.idx_w);
    localparam int TAG_W    = int'(FW.tag_w);
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BYTE_W   = $clog2(WORD_BYTES);
    localparam logic [31:0] BLK_MASK = 32'(BLKWORDS * WORD_BYTES - 1);
    localparam logic [WOFF_SW-1:0] LAST_WORD = WOFF_SW'(BLKWORDS - 1);

    // CPUID picks this cache's slot in the ccif arrays one level up;
    // nothing inside the cache depends on it.
    logic [31:0] unused_cpuid;
    assign unused_cpuid = CPUID;

    // Request address fields.
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [WOFF_SW-1:0] req_woff;

    assign req_idx  = imemaddr[BYTE_W+WOFF_W +: IDX_W];
    assign req_tag  = imemaddr[31 -: TAG_W];
    assign req_woff = (WOFF_W == 0) ? '0 : imemaddr[BYTE_W +: WOFF_SW];

    // Registered state.
    state_e             state_q, state_d;
    logic [31:0]        base_q, base_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [WOFF_SW-1:0] wcnt_q, wcnt_d;
    logic [31:0]        hit_count_q, miss_count_q;

    // Tag array interface.
    logic [WAYS-1:0]        rd_valid;
    logic [WAYS*TAG_W-1:0]  rd_tag;
    logic [WAYS*WORD_W-1:0] rd_data;
    logic [WAY_W-1:0]       rd_ptr;
    logic                   wr_en;
    logic                   commit;

    // Lookup results.
    logic             hit_any;
    word_t            hit_word;
    logic [WAY_W-1:0] victim;
    logic             free_found;
    logic             start_miss;

    icache_tag_array #(
        .SETS     (SETS),
        .WAYS     (WAYS),
        .BLKWORDS (BLKWORDS)
    ) u_tag_array (
        .CLK        (CLK),
        .RST        (RST),
        .flush_i    (iflush),
        .rd_idx_i   (req_idx),
        .rd_woff_i  (req_woff),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .rd_ptr_o   (rd_ptr),
        .wr_en_i    (wr_en),
        .wr_idx_i   (base_q[BYTE_W+WOFF_W +: IDX_W]),
        .wr_way_i   (victim_q),
        .wr_woff_i  (wcnt_q),
        .wr_data_i  (iload),
        .commit_i   (commit),
        .wr_tag_i   (base_q[31 -: TAG_W])
    );

    // Tag compare across the ways of the addressed set, and victim choice:
    // lowest invalid way, else the set's round-robin pointer.
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave a value held and infer a latch.
    always_comb begin
        hit_any    = 1'b0;
        hit_word   = '0;
        victim     = rd_ptr;
        free_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (rd_valid[w] && (rd_tag[w*TAG_W +: TAG_W] == req_tag)) begin
                hit_any  = 1'b1;
                hit_word = rd_data[w*WORD_W +: WORD_W];
            end
            if (!free_found && !rd_valid[w]) begin
                victim     = WAY_W'(w);
                free_found = 1'b1;
            end
        end
    end

    // Next-state and output logic of the IDLE/FILL controller.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        victim_d   = victim_q;
        wcnt_d     = wcnt_q;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        wr_en      = 1'b0;
        commit     = 1'b0;
        start_miss = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush in IDLE suppresses both the hit and a fill start;
                // the request simply retries next cycle.
                if (imemREN && !iflush) begin
                    if (hit_any) begin
                        ihit     = 1'b1;
                        imemload = hit_word;
                    end else begin
                        base_d     = imemaddr & ~BLK_MASK;
                        victim_d   = victim;
                        wcnt_d     = '0;
                        start_miss = 1'b1;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = base_q + (32'(wcnt_q) << BYTE_W);
                if (iflush) begin
                    state_d = IDLE;
                end else if (!iwait) begin
                    wr_en = 1'b1;
                    if (wcnt_q == LAST_WORD) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            base_q   <= '0;
            victim_q <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            victim_q <= victim_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Saturating hit-cycle and miss counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (ihit && (hit_count_q != '1)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (start_miss && (miss_count_q != '1)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc with SETS=8, WAYS=2, BLKWORDS=2.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_icache_assoc;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        iflush = 1'b0;
    logic        iwait = 1'b0;
    logic [31:0] iload = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    icache_assoc #(
        .CPUID    (0),
        .SETS     (8),
        .WAYS     (2),
        .BLKWORDS (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iflush     (iflush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic [31:0] ld;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_ren;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t vecs [0:25];

    function automatic vec_t mk(input logic ren, input logic [31:0] addr, input logic [31:0] ld,
                                input logic e_hit, input logic [31:0] e_load,
                                input logic e_ren, input logic [31:0] e_iaddr);
        vec_t v;
        v.ren = ren; v.addr = addr; v.ld = ld;
        v.e_hit = e_hit; v.e_load = e_load; v.e_ren = e_ren; v.e_iaddr = e_iaddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ren, input logic [31:0] addr, input logic wt,
                         input logic [31:0] ld, input logic fl, input logic rs);
        @(negedge CLK);
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = ld;
        iflush   = fl;
        RST      = rs;
        #1;
    endtask

    task automatic expect_out(input string name, input logic e_hit, input logic [31:0] e_load,
                              input logic e_ren, input logic [31:0] e_iaddr);
        check({name, ".ihit"},     {31'b0, ihit}, {31'b0, e_hit});
        check({name, ".imemload"}, imemload,      e_load);
        check({name, ".iREN"},     {31'b0, iREN}, {31'b0, e_ren});
        check({name, ".iaddr"},    iaddr,         e_iaddr);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].ren, vecs[i].addr, 1'b0, vecs[i].ld, 1'b0, 1'b0);
            expect_out($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_load,
                       vecs[i].e_ren, vecs[i].e_iaddr);
        end
    endtask

    initial begin
        int  latency;
        bit  done;

        // Scenario 1: cold miss of 0x40, then both words hit.
        vecs[0]  = mk(1, 32'h040, 32'h0,         0, 32'h0,         0, 32'h0);
        vecs[1]  = mk(1, 32'h040, 32'hAAAA0001, 0, 32'h0,         1, 32'h040);
        vecs[2]  = mk(1, 32'h040, 32'hAAAA0002, 0, 32'h0,         1, 32'h044);
        vecs[3]  = mk(1, 32'h040, 32'h0,         1, 32'hAAAA0001, 0, 32'h0);
        vecs[4]  = mk(1, 32'h044, 32'h0,         1, 32'hAAAA0002, 0, 32'h0);
        vecs[5]  = mk(0, 32'h044, 32'h0,         0, 32'h0,         0, 32'h0);
        // Scenario 2: 0x80 fills way 1, 0xC0 evicts way 0 (0x40).
        vecs[6]  = mk(1, 32'h080, 32'h0,         0, 32'h0,         0, 32'h0);
        vecs[7]  = mk(1, 32'h080, 32'hBBBB0001, 0, 32'h0,         1, 32'h080);
        vecs[8]  = mk(1, 32'h080, 32'hBBBB0002, 0, 32'h0,         1, 32'h084);
        vecs[9]  = mk(1, 32'h080, 32'h0,         1, 32'hBBBB0001, 0, 32'h0);
        vecs[10] = mk(1, 32'h040, 32'h0,         1, 32'hAAAA0001, 0, 32'h0);
        vecs[11] = mk(1, 32'h0C0, 32'h0,         0, 32'h0,         0, 32'h0);
        vecs[12] = mk(1, 32'h0C0, 32'hCCCC0001, 0, 32'h0,         1, 32'h0C0);
        vecs[13] = mk(1, 32'h0C0, 32'hCCCC0002, 0, 32'h0,         1, 32'h0C4);
        vecs[14] = mk(1, 32'h0C4, 32'h0,         1, 32'hCCCC0002, 0, 32'h0);
        vecs[15] = mk(1, 32'h084, 32'h0,         1, 32'hBBBB0002, 0, 32'h0);
        // 0x40 was evicted; refill goes to way 1 (pointer now 1), request
        // changes during FILL are ignored.
        vecs[16] = mk(1, 32'h040, 32'h0,         0, 32'h0,         0, 32'h0);
        vecs[17] = mk(1, 32'h1F0, 32'hDDDD0001, 0, 32'h0,         1, 32'h040);
        vecs[18] = mk(0, 32'h1F0, 32'hDDDD0002, 0, 32'h0,         1, 32'h044);
        vecs[19] = mk(1, 32'h040, 32'h0,         1, 32'hDDDD0001, 0, 32'h0);
        vecs[20] = mk(1, 32'h0C0, 32'h0,         1, 32'hCCCC0001, 0, 32'h0);
        // 0x80 was evicted by 0x40; refill takes way 0 (pointer back to 0).
        vecs[21] = mk(1, 32'h080, 32'h0,         0, 32'h0,         0, 32'h0);
        vecs[22] = mk(1, 32'h080, 32'hEEEE0001, 0, 32'h0,         1, 32'h080);
        vecs[23] = mk(1, 32'h080, 32'hEEEE0002, 0, 32'h0,         1, 32'h084);
        vecs[24] = mk(1, 32'h084, 32'h0,         1, 32'hEEEE0002, 0, 32'h0);
        vecs[25] = mk(0, 32'h000, 32'h0,         0, 32'h0,         0, 32'h0);

        // Reset state.
        do_reset();
        expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        check("reset.hit_count",  hit_count,  32'd0);
        check("reset.miss_count", miss_count, 32'd0);

        apply_vecs(0, 5);
        check("s1.miss_count", miss_count, 32'd1);
        check("s1.hit_count",  hit_count,  32'd2);

        apply_vecs(6, 25);
        check("s2.miss_count", miss_count, 32'd5);
        check("s2.hit_count",  hit_count,  32'd9);

        // Scenario 3: iwait high for 5 cycles inside FILL.
        do_reset();
        latency = -1;
        done    = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            drive(1'b1, 32'h040, (cyc >= 1 && cyc <= 5),
                  (cyc == 6) ? 32'hAAAA0001 : (cyc == 7) ? 32'hAAAA0002 : 32'hDEADBEEF,
                  1'b0, 1'b0);
            if (cyc >= 1 && cyc <= 5) begin
                expect_out($sformatf("wait%0d", cyc), 1'b0, 32'h0, 1'b1, 32'h040);
            end
            if (ihit) begin
                latency = cyc;
                done    = 1'b1;
                check("wait.hit_word", imemload, 32'hAAAA0001);
            end
        end
        check("wait.latency", latency, 32'd8);
        drive(1'b1, 32'h044, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_out("wait.word1", 1'b1, 32'hAAAA0002, 1'b0, 32'h0);

        // Scenario 4: flush on the second fill beat aborts the fill.
        do_reset();
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h040, 1'b0, 32'hAAAA0001, 1'b0, 1'b0);
        expect_out("fl.beat0", 1'b0, 32'h0, 1'b1, 32'h040);
        drive(1'b1, 32'h040, 1'b0, 32'hAAAA0002, 1'b1, 1'b0);
        expect_out("fl.beat1", 1'b0, 32'h0, 1'b1, 32'h044);
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_out("fl.idle", 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 32'h040, 1'b0, 32'hAAAA0001, 1'b0, 1'b0);
        expect_out("fl.refill", 1'b0, 32'h0, 1'b1, 32'h040);
        check("fl.miss_count", miss_count, 32'd2);
        drive(1'b1, 32'h040, 1'b0, 32'hAAAA0002, 1'b0, 1'b0);
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_out("fl.hit", 1'b1, 32'hAAAA0001, 1'b0, 32'h0);
        // Flush in IDLE masks a hit in the same cycle and drops the line.
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("fl.same_cycle", 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_out("fl.after", 1'b0, 32'h0, 1'b0, 32'h0);

        // Scenario 5: reset in the middle of a fill.
        do_reset();
        drive(1'b1, 32'h080, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h080, 1'b0, 32'h11110001, 1'b0, 1'b0);
        drive(1'b1, 32'h080, 1'b0, 32'h11110002, 1'b0, 1'b0);
        drive(1'b1, 32'h080, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_out("rst.prehit", 1'b1, 32'h11110001, 1'b0, 32'h0);
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h040, 1'b0, 32'hAAAA0001, 1'b0, 1'b1);
        expect_out("rst.infill", 1'b0, 32'h0, 1'b1, 32'h040);
        drive(1'b0, 32'h040, 1'b0, 32'hAAAA0002, 1'b0, 1'b0);
        expect_out("rst.after", 1'b0, 32'h0, 1'b0, 32'h0);
        check("rst.hit_count",  hit_count,  32'd0);
        check("rst.miss_count", miss_count, 32'd0);
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_out("rst.miss", 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_out("rst.fill", 1'b0, 32'h0, 1'b1, 32'h040);

        // Scenario 6: counters after one fill, three hits, two more misses.
        do_reset();
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h040, 1'b0, 32'hAAAA0001, 1'b0, 1'b0);
        drive(1'b0, 32'h040, 1'b0, 32'hAAAA0002, 1'b0, 1'b0);
        drive(1'b0, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h044, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h100, 1'b0, 32'h33330001, 1'b0, 1'b0);
        drive(1'b0, 32'h100, 1'b0, 32'h33330002, 1'b0, 1'b0);
        drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h200, 1'b0, 32'h44440001, 1'b0, 1'b0);
        expect_out("cnt.beat0", 1'b0, 32'h0, 1'b1, 32'h200);
        drive(1'b0, 32'h200, 1'b0, 32'h44440002, 1'b0, 1'b0);
        drive(1'b0, 32'h000, 1'b0, 32'h0, 1'b0, 1'b0);
        check("cnt.hit_count",  hit_count,  32'd3);
        check("cnt.miss_count", miss_count, 32'd3);
        drive(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_out("cnt.hit100", 1'b1, 32'h33330002, 1'b0, 32'h0);
        drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("cnt.flush", 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 32'h000, 1'b0, 32'h0, 1'b0, 1'b0);
        check("cnt.hit_final", hit_count, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
